bcd_updown_counter: RTL and testbench

Parametrised multi-digit BCD counter. Each digit is held as its own 4-bit BCD nibble. The counter counts up or down and supports parallel load with digit validation, synchronous clear, terminal-count flags and wrap reporting. It is the general-purpose decimal counter for display, timer and event-tally paths, and replaces fixed three-digit counters wherever digit count or direction must vary.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_digit.sv | 39 +++
 rtl/bcd_updown_counter.sv | 111 +++++++++++
 tb/tb_bcd_updown_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types, limits and digit helpers for the BCD up/down counter.
// Used by bcd_digit and bcd_updown_counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Out-of-range load nibbles (A..F) are stored as 9.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic logic bcd_is_bad(input bcd_digit_t d);
    return (d > BCD_MAX);
  endfunction

  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
    return (d == BCD_MAX) ? BCD_MIN : bcd_digit_t'(d + 4'd1);
  endfunction

  function automatic bcd_digit_t bcd_dec(input bcd_digit_t d);
    return (d == BCD_MIN) ? BCD_MAX : bcd_digit_t'(d - 4'd1);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down counter: clear, clamped load and modulo-10 step.
// Priority inside the digit is reset, clear, load, step.
import bcd_pkg::*;

module bcd_digit (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_load,
  input  bcd_digit_t i_load_digit,
  input  logic       i_step,
  input  logic       i_up,
  output bcd_digit_t o_value,
  output logic       o_is_max,
  output logic       o_is_min
);

  bcd_digit_t r_value;
  bcd_digit_t w_stepped;

  assign w_stepped = i_up ? bcd_inc(r_value) : bcd_dec(r_value);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_value <= BCD_MIN;
    end else if (i_clear) begin
      r_value <= BCD_MIN;
    end else if (i_load) begin
      r_value <= bcd_clamp(i_load_digit);
    end else if (i_step) begin
      r_value <= w_stepped;
    end
  end

  assign o_value  = r_value;
  assign o_is_max = (r_value == BCD_MAX);
  assign o_is_min = (r_value == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised NUM_DIGITS-digit BCD up/down counter with load, clear, tc, wrap and load_err.
// Optional macro BCD_COUNTER_SATURATE_EN: hold at all-9 / all-0 instead of wrapping.
import bcd_pkg::*;

module bcd_updown_counter #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [NUM_DIGITS-1:0]   digit_ena,
  output logic                    tc,
  output logic                    wrap,
  output logic                    load_err
);

  // No handshake: clear/load/en are sampled on every rising edge and count,
  // wrap and load_err reflect that sample one edge later; no backpressure.

  logic [NUM_DIGITS-1:0] w_is_max;
  logic [NUM_DIGITS-1:0] w_is_min;
  logic [NUM_DIGITS:0]   w_max_chain;
  logic [NUM_DIGITS:0]   w_min_chain;
  logic                  w_all_max;
  logic                  w_all_min;
  logic                  w_at_limit;
  logic                  w_hold;
  logic                  w_step_ok;
  logic                  w_wrap_next;
  logic                  w_bad_digit;
  logic                  w_load_err_next;
  logic                  r_wrap;
  logic                  r_load_err;

  // Chain bit i is set when every digit below i sits at its limit.
  always_comb begin
    w_max_chain    = '0;
    w_min_chain    = '0;
    w_max_chain[0] = 1'b1;
    w_min_chain[0] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_max_chain[i+1] = w_max_chain[i] & w_is_max[i];
      w_min_chain[i+1] = w_min_chain[i] & w_is_min[i];
    end
  end

  assign w_all_max  = w_max_chain[NUM_DIGITS];
  assign w_all_min  = w_min_chain[NUM_DIGITS];
  assign w_at_limit = up ? w_all_max : w_all_min;
  assign tc         = w_at_limit;

`ifdef BCD_COUNTER_SATURATE_EN
  assign w_hold      = w_at_limit;
  assign w_step_ok   = en & ~clear & ~load & ~w_hold;
  assign w_wrap_next = 1'b0;
`else
  assign w_hold      = 1'b0;
  assign w_step_ok   = en & ~clear & ~load & ~w_hold;
  assign w_wrap_next = w_step_ok & w_at_limit;
`endif

  always_comb begin
    digit_ena = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_ena[i] = w_step_ok & (up ? w_max_chain[i] : w_min_chain[i]);
    end
  end

  always_comb begin
    w_bad_digit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_bad_digit = w_bad_digit | bcd_is_bad(load_value[4*i +: 4]);
    end
  end

  assign w_load_err_next = load & ~clear & w_bad_digit;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_clear      (clear),
      .i_load       (load),
      .i_load_digit (load_value[4*g +: 4]),
      .i_step       (digit_ena[g]),
      .i_up         (up),
      .o_value      (count[4*g +: 4]),
      .o_is_max     (w_is_max[g]),
      .o_is_min     (w_is_min[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= w_wrap_next;
      r_load_err <= w_load_err_next;
    end
  end

  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomised scoreboard bench for bcd_updown_counter against a decimal-integer reference model.
// Define BCD_COUNTER_SATURATE_EN for both bench and RTL to check the saturating build.
module tb_bcd_updown_counter;

  localparam int ND  = 4;
  localparam int W   = 4 * ND;
  localparam int MOD = 10000;
`ifdef BCD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // clock / reset
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          en = 1'b0;
  logic          up = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_value = '0;
  logic [W-1:0]  count;
  logic [ND-1:0] digit_ena;
  logic          tc;
  logic          wrap;
  logic          load_err;

  always #5 clk = ~clk;

  bcd_updown_counter #(.NUM_DIGITS(ND)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .digit_ena  (digit_ena),
    .tc         (tc),
    .wrap       (wrap),
    .load_err   (load_err)
  );

  // scoreboard state
  logic [W+1:0] exp_q[$];       // {count, wrap, load_err} after the edge
  logic [ND:0]  exp_comb_q[$];  // {tc, digit_ena} before the edge
  int           n_checks = 0;
  int           n_fail = 0;
  int           m_val = 0;      // reference counter value as a plain integer

  function automatic int pow10(input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_to_int(input logic [W-1:0] lv);
    int r = 0;
    int d;
    for (int k = 0; k < ND; k++) begin
      d = int'(lv[4*k +: 4]);
      if (d > 9) d = 9;
      r = r + d * pow10(k);
    end
    return r;
  endfunction

  function automatic bit load_bad(input logic [W-1:0] lv);
    bit b = 1'b0;
    for (int k = 0; k < ND; k++) if (lv[4*k +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one cycle of stimulus plus model prediction
  task automatic drive(input bit c, input bit l, input logic [W-1:0] lv, input bit e, input bit u);
    bit            active;
    bit            at_lim;
    bit            hold;
    logic [ND-1:0] ena;
    int            p;
    int            nxt;
    bit            wr;
    bit            le;
    @(negedge clk);
    clear = c; load = l; load_value = lv; en = e; up = u;
    active = e && !c && !l;
    at_lim = u ? (m_val == MOD - 1) : (m_val == 0);
    hold   = SAT && at_lim;
    ena    = '0;
    if (active && !hold) begin
      for (int k = 0; k < ND; k++) begin
        p = pow10(k);
        ena[k] = u ? ((m_val % p) == p - 1) : ((m_val % p) == 0);
      end
    end
    exp_comb_q.push_back({at_lim, ena});
    nxt = m_val;
    wr  = 1'b0;
    if (c) nxt = 0;
    else if (l) nxt = load_to_int(lv);
    else if (active && !hold) begin
      nxt = u ? (m_val + 1) % MOD : (m_val + MOD - 1) % MOD;
      wr  = at_lim;
    end
    le = !c && l && load_bad(lv);
    m_val = nxt;
    exp_q.push_back({to_bcd(nxt), wr, le});
  endtask

  // monitors
  initial begin
    logic [W+1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", 32'(count), 32'(e[W+1:2]));
        check("wrap", 32'(wrap), 32'(e[1]));
        check("load_err", 32'(load_err), 32'(e[0]));
      end
    end
  end

  initial begin
    logic [ND:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_comb_q.size() > 0) begin
        e = exp_comb_q.pop_front();
        check("tc", 32'(tc), 32'(e[ND]));
        check("digit_ena", 32'(digit_ena), 32'(e[ND-1:0]));
      end
    end
  end

  // stimulus
  initial begin
    logic [W-1:0] lv;
    int           sel;
    #1;
    check("reset_count", 32'(count), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    check("reset_load_err", 32'(load_err), 32'h0);
    check("reset_tc_down", 32'(tc), 32'h1);
    check("reset_digit_ena", 32'(digit_ena), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_val = 0;

    drive(0, 1, 16'h0998, 1, 1);
    repeat (3) drive(0, 0, '0, 1, 1);
    drive(0, 1, 16'h9999, 0, 1);
    drive(0, 0, '0, 1, 1);
    drive(0, 0, '0, 0, 1);
    drive(0, 1, 16'h0000, 0, 0);
    drive(0, 0, '0, 1, 0);
    drive(0, 0, '0, 0, 0);
    drive(0, 1, 16'h3A5F, 0, 1);
    drive(0, 0, '0, 0, 1);
    drive(0, 1, 16'h1234, 0, 1);
    drive(0, 1, 16'h0567, 0, 1);
    drive(1, 1, 16'hFFFF, 1, 1);
    drive(0, 1, 16'h9999, 1, 1);
    drive(0, 0, '0, 0, 1);

    // asynchronous reset between edges with count=4321
    drive(0, 1, 16'h4321, 1, 1);
    @(posedge clk);
    #3;
    en = 1'b0; load = 1'b0;
    reset = 1'b1;
    #1;
    check("async_reset_count", 32'(count), 32'h0);
    check("async_reset_wrap", 32'(wrap), 32'h0);
    check("async_reset_load_err", 32'(load_err), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_val = 0;

    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: lv = W'($urandom);
        1: lv = to_bcd(MOD - 1 - $urandom_range(0, 3));
        2: lv = to_bcd($urandom_range(0, 3));
        default: lv = to_bcd($urandom_range(0, MOD - 1));
      endcase
      drive($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 12, lv,
            $urandom_range(0, 99) < 75, $urandom_range(0, 1) == 1);
    end
    drive(0, 0, '0, 0, 1);

    for (int n = 0; n < 10 && (exp_q.size() > 0 || exp_comb_q.size() > 0); n++) @(posedge clk);
    #3;
    check("drain_exp_q", 32'(exp_q.size()), 32'h0);
    check("drain_exp_comb_q", 32'(exp_comb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
